// File: rtl/pong_core.sv
`default_nettype none
// ============================================================================
// Module   : pong_core
// Purpose  : LED-matrix pong engine covering ball, paddles, scoring and serve/point/game-over flow.
//            Optional paddle spin when PONG_SPIN_EN is defined.
// Revision : 1.0
// ============================================================================
module pong_core #(
    parameter int COLS        = 16,
    parameter int ROWS        = 16,
    parameter int PADDLE_W    = 3,
    parameter int BALL_DIV    = 20,
    parameter int PADDLE_DIV  = 4,
    parameter int SERVE_DELAY = 50,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    l_up,
    input  logic                    l_down,
    input  logic                    r_up,
    input  logic                    r_down,
    output logic [$clog2(COLS)-1:0] ball_x,
    output logic [$clog2(ROWS)-1:0] ball_y,
    output logic [ROWS-1:0]         lpaddle,
    output logic [ROWS-1:0]         rpaddle,
    output logic [SCORE_W-1:0]      score_l,
    output logic [SCORE_W-1:0]      score_r,
    output logic                    point_l,
    output logic                    point_r,
    output logic                    game_over
);

    localparam int XW  = $clog2(COLS);
    localparam int YW  = $clog2(ROWS);
    localparam int DCW = $clog2(SERVE_DELAY + 1);
    localparam int BCW = $clog2(BALL_DIV + 1);
    localparam int PCW = $clog2(PADDLE_DIV + 1);

    localparam logic [1:0] S_SERVE = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_POINT = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    localparam logic [XW-1:0]      c_X_CENTRE = XW'(COLS / 2);
    localparam logic [XW-1:0]      c_X_RIGHT  = XW'(COLS - 1);
    localparam logic [YW-1:0]      c_Y_CENTRE = YW'(ROWS / 2);
    localparam logic [YW-1:0]      c_TOP_MAX  = YW'(ROWS - PADDLE_W);
    localparam logic [YW-1:0]      c_TOP_INIT = YW'((ROWS - PADDLE_W) / 2);
    localparam logic [DCW-1:0]     c_D_LAST   = DCW'(SERVE_DELAY - 1);
    localparam logic [BCW-1:0]     c_B_LAST   = BCW'(BALL_DIV - 1);
    localparam logic [PCW-1:0]     c_P_LAST   = PCW'(PADDLE_DIV - 1);
    localparam logic [SCORE_W-1:0] c_WIN      = SCORE_W'(WIN_SCORE);
    localparam logic signed [YW+1:0] c_Y_MAX  = (YW+2)'(ROWS - 1);

    logic [1:0]         r_state;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic               r_dx;          // 1: moving right, 0: moving left
    logic signed [1:0]  r_dy;
    logic [YW-1:0]      r_ltop;
    logic [YW-1:0]      r_rtop;
    logic [SCORE_W-1:0] r_score_l;
    logic [SCORE_W-1:0] r_score_r;
    logic               r_point_l;
    logic               r_point_r;
    logic               r_left_scored;
    logic [DCW-1:0]     r_dcnt;
    logic [BCW-1:0]     r_bcnt;
    logic [PCW-1:0]     r_pcnt;

    logic signed [YW+1:0] w_y_s;
    logic signed [YW+1:0] w_dy_s;
    logic signed [YW+1:0] w_ny_try;
    logic signed [YW+1:0] w_ny_s;
    logic signed [1:0]    w_dy_refl;
    logic signed [1:0]    w_dy_hit;
    logic [YW-1:0]        w_ny;
    logic [XW-1:0]        w_nx;
    logic                 w_at_left;
    logic                 w_at_right;
    logic                 w_hit;
    logic                 w_miss;
    logic                 w_any_btn;
    logic [SCORE_W-1:0]   w_scorer_score;
    logic [ROWS-1:0]      w_lmap;
    logic [ROWS-1:0]      w_rmap;
`ifdef PONG_SPIN_EN
    logic [YW-1:0]        w_off;
`endif

    function automatic logic f_covers(input logic [YW-1:0] top, input logic [YW-1:0] row);
        return (row >= top) && ({1'b0, row} < ({1'b0, top} + (YW+1)'(PADDLE_W)));
    endfunction

    function automatic logic [YW-1:0] f_paddle_next(input logic [YW-1:0] top,
                                                    input logic up, input logic dn);
        if (up && !dn && top != '0)
            return top - 1'b1;
        if (dn && !up && top != c_TOP_MAX)
            return top + 1'b1;
        return top;
    endfunction

    // Candidate ball step: wall reflection first, then paddle column test.
    always_comb begin
        w_y_s    = $signed({2'b00, r_y});
        w_dy_s   = {{YW{r_dy[1]}}, r_dy};
        w_ny_try = w_y_s + w_dy_s;
        if (w_ny_try[YW+1] || (w_ny_try > c_Y_MAX)) begin
            w_dy_refl = -r_dy;
            w_ny_s    = w_y_s - w_dy_s;
        end else begin
            w_dy_refl = r_dy;
            w_ny_s    = w_ny_try;
        end
        w_ny       = w_ny_s[YW-1:0];
        w_nx       = r_dx ? (r_x + 1'b1) : (r_x - 1'b1);
        w_at_left  = (w_nx == '0);
        w_at_right = (w_nx == c_X_RIGHT);
        w_hit      = (w_at_left && f_covers(r_ltop, w_ny)) ||
                     (w_at_right && f_covers(r_rtop, w_ny));
        w_miss     = (w_at_left || w_at_right) && !w_hit;
`ifdef PONG_SPIN_EN
        w_off = w_at_left ? (w_ny - r_ltop) : (w_ny - r_rtop);
        if (PADDLE_W == 1)
            w_dy_hit = w_dy_refl;
        else if (w_off == '0)
            w_dy_hit = -2'sd1;
        else if (w_off == YW'(PADDLE_W - 1))
            w_dy_hit = 2'sd1;
        else
            w_dy_hit = 2'sd0;
`else
        w_dy_hit = w_dy_refl;
`endif
    end

    always_comb begin
        w_any_btn      = l_up | l_down | r_up | r_down;
        w_scorer_score = r_left_scored ? r_score_l : r_score_r;
        w_lmap         = '0;
        w_rmap         = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_lmap[r] = f_covers(r_ltop, YW'(r));
            w_rmap[r] = f_covers(r_rtop, YW'(r));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_SERVE;
            r_x           <= c_X_CENTRE;
            r_y           <= c_Y_CENTRE;
            r_dx          <= 1'b1;
            r_dy          <= 2'sd1;
            r_ltop        <= c_TOP_INIT;
            r_rtop        <= c_TOP_INIT;
            r_score_l     <= '0;
            r_score_r     <= '0;
            r_point_l     <= 1'b0;
            r_point_r     <= 1'b0;
            r_left_scored <= 1'b0;
            r_dcnt        <= '0;
            r_bcnt        <= '0;
            r_pcnt        <= '0;
        end else begin
            r_point_l <= 1'b0;
            r_point_r <= 1'b0;
            if (r_state == S_OVER) begin
                // Restart ignores tick; paddles stay where they were.
                if (w_any_btn) begin
                    r_state   <= S_SERVE;
                    r_x       <= c_X_CENTRE;
                    r_y       <= c_Y_CENTRE;
                    r_dx      <= 1'b1;
                    r_dy      <= 2'sd1;
                    r_score_l <= '0;
                    r_score_r <= '0;
                    r_dcnt    <= '0;
                    r_bcnt    <= '0;
                    r_pcnt    <= '0;
                end
            end else if (tick) begin
                if (r_pcnt == c_P_LAST) begin
                    r_pcnt <= '0;
                    r_ltop <= f_paddle_next(r_ltop, l_up, l_down);
                    r_rtop <= f_paddle_next(r_rtop, r_up, r_down);
                end else begin
                    r_pcnt <= r_pcnt + 1'b1;
                end

                case (r_state)
                    S_SERVE: begin
                        if (r_dcnt == c_D_LAST) begin
                            r_dcnt  <= '0;
                            r_bcnt  <= '0;
                            r_state <= S_PLAY;
                        end else begin
                            r_dcnt <= r_dcnt + 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (r_bcnt == c_B_LAST) begin
                            r_bcnt <= '0;
                            r_y    <= w_ny;
                            if (w_hit) begin
                                r_dx <= ~r_dx;
                                r_dy <= w_dy_hit;
                            end else begin
                                r_x  <= w_nx;
                                r_dy <= w_dy_refl;
                            end
                            if (w_miss) begin
                                r_state       <= S_POINT;
                                r_dcnt        <= '0;
                                r_left_scored <= w_at_right;
                                if (w_at_right) begin
                                    r_point_l <= 1'b1;
                                    if (r_score_l != c_WIN)
                                        r_score_l <= r_score_l + 1'b1;
                                end else begin
                                    r_point_r <= 1'b1;
                                    if (r_score_r != c_WIN)
                                        r_score_r <= r_score_r + 1'b1;
                                end
                            end
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                    S_POINT: begin
                        if (r_dcnt == c_D_LAST) begin
                            r_dcnt <= '0;
                            if (w_scorer_score == c_WIN) begin
                                r_state <= S_OVER;
                            end else begin
                                // Next serve heads toward whoever conceded.
                                r_state <= S_SERVE;
                                r_x     <= c_X_CENTRE;
                                r_y     <= c_Y_CENTRE;
                                r_dx    <= r_left_scored;
                                r_dy    <= 2'sd1;
                            end
                        end else begin
                            r_dcnt <= r_dcnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ball_x    = r_x;
    assign ball_y    = r_y;
    assign lpaddle   = w_lmap;
    assign rpaddle   = w_rmap;
    assign score_l   = r_score_l;
    assign score_r   = r_score_r;
    assign point_l   = r_point_l;
    assign point_r   = r_point_r;
    assign game_over = (r_state == S_OVER);

endmodule
`default_nettype wire

// File: tb/tb_pong_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_core
// Purpose  : Randomised bench for pong_core against a tick-counting game model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pong_core;

    localparam int COLS = 8;
    localparam int ROWS = 8;
    localparam int PW   = 3;
    localparam int BD   = 2;
    localparam int PD   = 2;
    localparam int SD   = 3;
    localparam int SW   = 4;
    localparam int WIN  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1, tick = 1'b0;
    logic l_up = 1'b0, l_down = 1'b0, r_up = 1'b0, r_down = 1'b0;
    logic [2:0]    ball_x, ball_y;
    logic [7:0]    lpaddle, rpaddle;
    logic [SW-1:0] score_l, score_r;
    logic          point_l, point_r, game_over;

    always #5 clk = ~clk;

    pong_core #(
        .COLS(COLS), .ROWS(ROWS), .PADDLE_W(PW), .BALL_DIV(BD), .PADDLE_DIV(PD),
        .SERVE_DELAY(SD), .SCORE_W(SW), .WIN_SCORE(WIN)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .l_up(l_up), .l_down(l_down), .r_up(r_up), .r_down(r_down),
        .ball_x(ball_x), .ball_y(ball_y), .lpaddle(lpaddle), .rpaddle(rpaddle),
        .score_l(score_l), .score_r(score_r), .point_l(point_l), .point_r(point_r),
        .game_over(game_over)
    );

    typedef enum int {PH_SERVE, PH_PLAY, PH_POINT, PH_OVER} phase_t;

    phase_t ph;
    int mx, my, mdx, mdy, mlt, mrt, msl, msr, mpl, mpr;
    int ptk, btk, phtk;
    bit mleft;
    int n_vec = 0, n_err = 0;
    int dut_pts = 0, mdl_pts = 0, dut_overs = 0, mdl_overs = 0;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_vec++;
        if (got !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bitmap(input int top);
        int m = 0;
        for (int r = 0; r < ROWS; r++)
            if (r >= top && r < top + PW) m |= (1 << r);
        return m;
    endfunction

    function automatic int paddle_move(input int top, input logic up, input logic dn);
        if (up && !dn) return (top > 0) ? top - 1 : 0;
        if (dn && !up) return (top < ROWS - PW) ? top + 1 : top;
        return top;
    endfunction

    function automatic void centre_ball();
        mx = COLS / 2; my = ROWS / 2; mdy = 1;
    endfunction

    function automatic void model_reset();
        ph = PH_SERVE; centre_ball(); mdx = 1;
        mlt = (ROWS - PW) / 2; mrt = mlt;
        msl = 0; msr = 0; mpl = 0; mpr = 0;
        ptk = 0; btk = 0; phtk = 0; mleft = 0;
    endfunction

    function automatic void ball_step(input int olt, input int ort);
        int nx, ny, top;
        ny = my + mdy;
        if (ny < 0 || ny > ROWS - 1) begin
            mdy = -mdy;
            ny  = my + mdy;
        end
        nx = mx + mdx;
        if (nx == 0 || nx == COLS - 1) begin
            top = (nx == 0) ? olt : ort;
            if (ny >= top && ny < top + PW) begin
`ifdef PONG_SPIN_EN
                if (PW > 1) mdy = (ny == top) ? -1 : (ny == top + PW - 1) ? 1 : 0;
`endif
                mdx = -mdx;
                my  = ny;
            end else begin
                mx = nx; my = ny;
                mleft = (nx == COLS - 1);
                if (mleft) begin
                    if (msl < WIN) msl++;
                    mpl = 1;
                end else begin
                    if (msr < WIN) msr++;
                    mpr = 1;
                end
                ph = PH_POINT; phtk = 0;
            end
        end else begin
            mx = nx; my = ny;
        end
    endfunction

    function automatic void model_step(input logic rst, input logic tk,
                                       input logic lu, input logic ld,
                                       input logic ru, input logic rd);
        int olt, ort;
        if (rst) begin
            model_reset();
            return;
        end
        mpl = 0; mpr = 0;
        if (ph == PH_OVER) begin
            if (lu || ld || ru || rd) begin
                ph = PH_SERVE; centre_ball(); mdx = 1;
                msl = 0; msr = 0; ptk = 0; btk = 0; phtk = 0;
            end
            return;
        end
        if (!tk) return;
        olt = mlt; ort = mrt;
        ptk++;
        if (ptk % PD == 0) begin
            mlt = paddle_move(mlt, lu, ld);
            mrt = paddle_move(mrt, ru, rd);
        end
        case (ph)
            PH_SERVE: begin
                phtk++;
                if (phtk == SD) begin ph = PH_PLAY; phtk = 0; btk = 0; end
            end
            PH_PLAY: begin
                btk++;
                if (btk % BD == 0) ball_step(olt, ort);
            end
            PH_POINT: begin
                phtk++;
                if (phtk == SD) begin
                    phtk = 0;
                    if ((mleft ? msl : msr) == WIN) ph = PH_OVER;
                    else begin
                        ph = PH_SERVE; centre_ball();
                        mdx = mleft ? 1 : -1;
                    end
                end
            end
            default: ;
        endcase
    endfunction

    task automatic check_all();
        check("ball_x", 32'(ball_x), mx);
        check("ball_y", 32'(ball_y), my);
        check("lpaddle", 32'(lpaddle), bitmap(mlt));
        check("rpaddle", 32'(rpaddle), bitmap(mrt));
        check("score_l", 32'(score_l), msl);
        check("score_r", 32'(score_r), msr);
        check("point_l", 32'(point_l), mpl);
        check("point_r", 32'(point_r), mpr);
        check("game_over", 32'(game_over), (ph == PH_OVER) ? 1 : 0);
    endtask

    task automatic cycle(input logic rst, input logic tk, input logic lu,
                         input logic ld, input logic ru, input logic rd);
        @(negedge clk);
        reset = rst; tick = tk; l_up = lu; l_down = ld; r_up = ru; r_down = rd;
        @(posedge clk);
        model_step(rst, tk, lu, ld, ru, rd);
        #1;
        check_all();
        dut_pts   += int'(point_l) + int'(point_r);
        mdl_pts   += mpl + mpr;
        dut_overs += int'(game_over);
        mdl_overs += (ph == PH_OVER) ? 1 : 0;
    endtask

    initial begin
        model_reset();
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Serve hold then first free steps, then a frozen stretch with tick low.
        repeat (12) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4)  cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (6)  cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (6)  cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6000; i++) begin
            cycle(($urandom % 700) == 0,
                  ($urandom % 10) < 8,
                  ($urandom % 4) == 0, ($urandom % 4) == 0,
                  ($urandom % 4) == 0, ($urandom % 4) == 0);
        end
        check("point_pulses", 32'(dut_pts), mdl_pts);
        check("gameover_cycles", 32'(dut_overs), mdl_overs);
        check("points_seen", 32'(mdl_pts > 4), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
